ro_freq_counter: RTL and testbench

Measurement front end for the 127-stage HVT ring-oscillator sensor. It enables the oscillator, waits a settle interval, then counts oscillator rising edges over a fixed window of reference-clock cycles. It reports the count through a valid/ack handshake to the VT-sensor readout logic. It sits between one RO macro (drives its enable/select, consumes its output) and the sensor register interface.

---
 rtl/ro_freq_counter.sv | 156 +++++++++++++++
 tb/tb_ro_freq_counter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator edge counter: settle, count RO rising edges over a fixed window, hand the result over a valid/ack handshake.
// Result lands SETTLE_CYCLES+WINDOW_CYCLES+1 cycles after start; RO_CNT_SATURATE_EN selects a saturating count (default wraps).
module ro_freq_counter #(
  parameter int CNT_W         = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_Sel,
  input  logic             i_Ack,
  input  logic             i_RO_out,
  output logic             o_RO_Enable,
  output logic             o_RO_Sel,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Overflow
);

  localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES - 1) ? SETTLE_CYCLES : WINDOW_CYCLES - 1;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q,  state_d;
  logic [TW-1:0]     timer_q,  timer_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic              en_q,     en_d;
  logic              sel_q,    sel_d;
  logic              busy_q,   busy_d;
  logic              valid_q,  valid_d;
  logic              sync1_q,  sync2_q, hist_q;

  logic              edge_det;
  logic              cnt_max;
  logic [CNT_W-1:0]  cnt_next;
  logic              start_ok;

  assign edge_det = sync2_q & ~hist_q;
  assign cnt_max  = &cnt_q;
  assign start_ok = i_Start && ((state_q == IDLE) || (state_q == DONE));

`ifdef RO_CNT_SATURATE_EN
  assign cnt_next = cnt_max ? cnt_q : cnt_q + 1'b1;
`else
  assign cnt_next = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    en_d    = en_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    valid_d = valid_q;

    if (start_ok) begin
      state_d = SETTLE;
      timer_d = SETTLE_LOAD;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      sel_d   = i_Sel;
      en_d    = 1'b1;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          // Synchronizer latency drains here, so edges seen now belong before the window.
          if (timer_q == '0) begin
            state_d = COUNT;
            timer_d = WINDOW_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        COUNT: begin
          if (edge_det) begin
            cnt_d = cnt_next;
            if (cnt_max) ovf_d = 1'b1;
          end
          if (timer_q == '0) begin
            state_d = DONE;
            count_d = edge_det ? cnt_next : cnt_q;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        DONE: begin
          if (i_Ack) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      sync1_q <= i_RO_out;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign o_RO_Enable = en_q;
  assign o_RO_Sel    = sel_q;
  assign o_Busy      = busy_q;
  assign o_Valid     = valid_q;
  assign o_Count     = count_q;
  assign o_Overflow  = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: main instance (16-bit, 800-cycle window) and a 4-bit overflow instance.
module tb_ro_freq_counter;

  localparam int S   = 8;
  localparam int W   = 800;
  localparam int W2  = 100;
  localparam int LAT = S + W + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_m = 1'b0, sel_in_m = 1'b0, ack_m = 1'b0;
  logic        start_o = 1'b0, ack_o = 1'b0;
  logic        ro_a, ro_b, ro_main;
  logic        stuck_en = 1'b0, stuck_val = 1'b0;

  logic        en_m, sel_m, busy_m, valid_m, ovf_m;
  logic [15:0] count_m;
  logic        en_o, sel_o, busy_o, valid_o, ovf_o;
  logic [3:0]  count_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  initial begin
    ro_a = 1'b0;
    #3;
    forever #40 ro_a = ~ro_a;
  end

  initial begin
    ro_b = 1'b0;
    #7;
    forever #20 ro_b = ~ro_b;
  end

  assign ro_main = stuck_en ? stuck_val : ro_a;

  ro_freq_counter #(.CNT_W(16), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)) u_main (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_m), .i_Sel(sel_in_m), .i_Ack(ack_m),
    .i_RO_out(ro_main), .o_RO_Enable(en_m), .o_RO_Sel(sel_m), .o_Busy(busy_m),
    .o_Valid(valid_m), .o_Count(count_m), .o_Overflow(ovf_m)
  );

  ro_freq_counter #(.CNT_W(4), .WINDOW_CYCLES(W2), .SETTLE_CYCLES(S)) u_ovf (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_o), .i_Sel(1'b0), .i_Ack(ack_o),
    .i_RO_out(ro_b), .o_RO_Enable(en_o), .o_RO_Sel(sel_o), .o_Busy(busy_o),
    .o_Valid(valid_o), .o_Count(count_o), .o_Overflow(ovf_o)
  );

  task automatic pulse_start_main(input logic sel);
    @(posedge clk); #1;
    start_m  = 1'b1;
    sel_in_m = sel;
    @(posedge clk); #1;
    start_m  = 1'b0;
  endtask

  // Called just after the start edge; returns cycles until o_Valid plus per-cycle tallies.
  task automatic wait_main(input int inj_a, input int inj_b, input logic sel_exp,
                           output int lat, output int en_n, output int busy_n, output int sel_bad);
    lat = 0; en_n = 0; busy_n = 0; sel_bad = 0;
    while (valid_m !== 1'b1 && lat <= 2000) begin
      en_n   += int'(en_m === 1'b1);
      busy_n += int'(busy_m === 1'b1);
      if (sel_m !== sel_exp) sel_bad++;
      start_m  = (lat == inj_a) || (lat == inj_b);
      sel_in_m = start_m ? ~sel_exp : sel_exp;
      @(posedge clk); #1;
      lat++;
    end
    start_m = 1'b0;
  endtask

  task automatic test_reset;
    logic [11:0] got;
    got = {en_m, sel_m, busy_m, valid_m, ovf_m, (count_m != 16'd0),
           en_o, sel_o, busy_o, valid_o, ovf_o, (count_o != 4'd0)};
    tests_run++;
    if (got !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_values: outputs=%b required=%b", got, 12'd0);
    end
  endtask

  task automatic test_basic;
    int lat, en_n, busy_n, sel_bad;
    pulse_start_main(1'b0);
    tests_run++;
    if (en_m !== 1'b1 || busy_m !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_start_edge: en=%b busy=%b required en=1 busy=1", en_m, busy_m);
    end
    wait_main(-1, -1, 1'b0, lat, en_n, busy_n, sel_bad);
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d cycles required %0d", lat, LAT);
    end
    tests_run++;
    if (count_m < 16'd99 || count_m > 16'd101) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d required 99..101", count_m);
    end
    tests_run++;
    if (ovf_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_overflow: got %b required 0", ovf_m);
    end
    tests_run++;
    if (en_n !== LAT || busy_n !== LAT) begin
      tests_failed++;
      $display("FAIL basic_enable_span: en cycles %0d busy cycles %0d required %0d", en_n, busy_n, LAT);
    end
    tests_run++;
    if (en_m !== 1'b0 || busy_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_outputs: en=%b busy=%b required 0 0", en_m, busy_m);
    end
  endtask

  task automatic test_handshake;
    int unstable, lat, en_n, busy_n, sel_bad;
    logic [15:0] c0;
    c0 = count_m;
    unstable = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (valid_m !== 1'b1 || count_m !== c0 || count_m < 16'd99 || count_m > 16'd101) unstable++;
    end
    tests_run++;
    if (unstable !== 0) begin
      tests_failed++;
      $display("FAIL hold_without_ack: %0d unstable cycles required 0", unstable);
    end
    ack_m = 1'b1;
    @(posedge clk); #1;
    ack_m = 1'b0;
    tests_run++;
    if (valid_m !== 1'b0 || busy_m !== 1'b0 || en_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_clears_valid: valid=%b busy=%b en=%b required 0 0 0", valid_m, busy_m, en_m);
    end
    ack_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_m = 1'b0;
    tests_run++;
    if (valid_m !== 1'b0 || busy_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_in_idle: valid=%b busy=%b required 0 0", valid_m, busy_m);
    end
    pulse_start_main(1'b0);
    wait_main(-1, -1, 1'b0, lat, en_n, busy_n, sel_bad);
    start_m = 1'b1;
    ack_m   = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    ack_m   = 1'b0;
    tests_run++;
    if (valid_m !== 1'b0 || busy_m !== 1'b1 || en_m !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_from_done: valid=%b busy=%b en=%b required 0 1 1", valid_m, busy_m, en_m);
    end
    wait_main(-1, -1, 1'b0, lat, en_n, busy_n, sel_bad);
    tests_run++;
    if (lat !== LAT || count_m < 16'd99 || count_m > 16'd101) begin
      tests_failed++;
      $display("FAIL restart_result: latency %0d count %0d required %0d and 99..101", lat, count_m, LAT);
    end
  endtask

  task automatic test_busy;
    int lat, en_n, busy_n, sel_bad;
    pulse_start_main(1'b1);
    wait_main(3, 400, 1'b1, lat, en_n, busy_n, sel_bad);
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: latency %0d required %0d", lat, LAT);
    end
    tests_run++;
    if (sel_bad !== 0 || sel_m !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_sel_held: %0d cycles with wrong sel, sel=%b required 0 and 1", sel_bad, sel_m);
    end
    tests_run++;
    if (count_m < 16'd99 || count_m > 16'd101) begin
      tests_failed++;
      $display("FAIL busy_count: got %0d required 99..101", count_m);
    end
  endtask

  task automatic test_reset_mid;
    int lat, en_n, busy_n, sel_bad;
    logic [5:0] got;
    pulse_start_main(1'b1);
    repeat (S + 1 + 300) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = {en_m, sel_m, busy_m, valid_m, ovf_m, (count_m != 16'd0)};
    tests_run++;
    if (got !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_count: outputs=%b required %b", got, 6'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulse_start_main(1'b0);
    wait_main(-1, -1, 1'b0, lat, en_n, busy_n, sel_bad);
    tests_run++;
    if (lat !== LAT || count_m < 16'd99 || count_m > 16'd101 || ovf_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_recovery: latency %0d count %0d ovf %b required %0d 99..101 0",
               lat, count_m, ovf_m, LAT);
    end
  endtask

  task automatic test_overflow;
    int lat;
    logic [3:0] exp_cnt;
`ifdef RO_CNT_SATURATE_EN
    exp_cnt = 4'd15;
`else
    exp_cnt = 4'd9;
`endif
    @(posedge clk); #1;
    start_o = 1'b1;
    @(posedge clk); #1;
    start_o = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat <= 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat !== S + W2 + 1) begin
      tests_failed++;
      $display("FAIL overflow_latency: got %0d required %0d", lat, S + W2 + 1);
    end
    tests_run++;
    if (count_o !== exp_cnt) begin
      tests_failed++;
      $display("FAIL overflow_count: got %0d required %0d", count_o, exp_cnt);
    end
    tests_run++;
    if (ovf_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_flag: got %b required 1", ovf_o);
    end
  endtask

  task automatic test_stuck;
    int lat, en_n, busy_n, sel_bad;
    stuck_en = 1'b1;
    for (int v = 0; v < 2; v++) begin
      stuck_val = v[0];
      repeat (5) @(posedge clk);
      pulse_start_main(1'b0);
      wait_main(-1, -1, 1'b0, lat, en_n, busy_n, sel_bad);
      tests_run++;
      if (lat !== LAT || count_m !== 16'd0) begin
        tests_failed++;
        $display("FAIL stuck_%0d: latency %0d count %0d required %0d 0", v, lat, count_m, LAT);
      end
    end
    stuck_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_basic;
    test_handshake;
    test_busy;
    test_reset_mid;
    test_overflow;
    test_stuck;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
